// File: rtl/w_inport_requester.sv
// West input port of a mesh router: buffers incoming flits, routes each packet
// dimension-ordered (X then Y) and forwards it through the crossbar one packet at a time.
module w_inport_requester #(
    parameter int         FLIT_W     = 32,
    parameter int         FIFO_DEPTH = 4,
    parameter logic [3:0] MY_X       = 4'd0,
    parameter logic [3:0] MY_Y       = 4'd0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [FLIT_W-1:0] w_flit_i,
    input  logic [1:0]        w_flit_type_i,
    input  logic              w_valid_i,
    output logic              w_ready_o,
    output logic [2:0]        w_nexthop_addr_o,
    input  logic              n_grant_w_i,
    input  logic              s_grant_w_i,
    input  logic              e_grant_w_i,
    input  logic              l_grant_w_i,
    output logic [FLIT_W+1:0] xbar_flit_o,
    output logic              xbar_valid_o,
    input  logic              xbar_ready_i,
    output logic              change_order_o,
    output logic              err_o
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] TYPE_BODY = 2'b01;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    localparam logic [2:0] ROUTE_N    = 3'b000;
    localparam logic [2:0] ROUTE_S    = 3'b001;
    localparam logic [2:0] ROUTE_E    = 3'b011;
    localparam logic [2:0] ROUTE_L    = 3'b100;
    localparam logic [2:0] ROUTE_NONE = 3'b111;

    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_WAIT_GRANT = 2'd1;
    localparam logic [1:0] ST_FORWARD    = 2'd2;
    localparam logic [1:0] ST_DROP       = 2'd3;

    logic [FLIT_W+1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [CNT_W-1:0]  count_reg;
    logic [CNT_W-1:0]  count_next;
    logic              w_ready_reg;

    logic [1:0]        state_reg;
    logic [1:0]        state_next;
    logic [2:0]        route_reg;
    logic [2:0]        route_next;
    logic              err_reg;
    logic              err_next;
    logic              change_reg;
    logic              change_next;

    logic [FLIT_W+1:0] head_entry;
    logic [1:0]        head_type;
    logic [3:0]        dest_x;
    logic [3:0]        dest_y;
    logic              fifo_empty;
    logic              head_is_last;
    logic              head_is_orphan;
    logic [2:0]        route_calc;
    logic              routed_grant;
    logic              push;
    logic              pop;
    logic              xfer;
    logic              drop_pop;
    logic              orphan_pop;
    logic              valid_int;

    // The head entry is read asynchronously so the crossbar sees it in the same cycle.
    assign head_entry     = mem[rd_ptr_reg];
    assign head_type      = head_entry[FLIT_W+1:FLIT_W];
    assign dest_x         = head_entry[7:4];
    assign dest_y         = head_entry[3:0];
    assign fifo_empty     = (count_reg == '0);
    assign head_is_last   = head_type[1];
    assign head_is_orphan = (head_type == TYPE_BODY) || (head_type == TYPE_TAIL);

    always_comb begin
        route_calc = ROUTE_L;
        if (dest_x > MY_X) begin
            route_calc = ROUTE_E;
        end else if (dest_y > MY_Y) begin
            route_calc = ROUTE_N;
        end else if (dest_y < MY_Y) begin
            route_calc = ROUTE_S;
        end
    end

    always_comb begin
        case (route_reg)
            ROUTE_N: routed_grant = n_grant_w_i;
            ROUTE_S: routed_grant = s_grant_w_i;
            ROUTE_E: routed_grant = e_grant_w_i;
            ROUTE_L: routed_grant = l_grant_w_i;
            default: routed_grant = 1'b0;
        endcase
    end

    assign valid_int  = (state_reg == ST_FORWARD) && !fifo_empty && routed_grant;
    assign xfer       = valid_int && xbar_ready_i;
    assign drop_pop   = (state_reg == ST_DROP) && !fifo_empty;
    assign orphan_pop = (state_reg == ST_IDLE) && !fifo_empty && head_is_orphan;
    assign pop        = xfer || drop_pop || orphan_pop;
    assign push       = w_valid_i && w_ready_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    always_comb begin
        state_next  = state_reg;
        route_next  = route_reg;
        err_next    = 1'b0;
        change_next = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_is_orphan) begin
                        err_next = 1'b1;
                    end else if (dest_x < MY_X) begin
                        // West-bound traffic arriving on the west port would be a U-turn.
                        err_next   = 1'b1;
                        state_next = ST_DROP;
                    end else begin
                        route_next = route_calc;
                        state_next = ST_WAIT_GRANT;
                    end
                end
            end
            ST_WAIT_GRANT: begin
                if (routed_grant) begin
                    state_next = ST_FORWARD;
                end
            end
            ST_FORWARD: begin
                if (xfer && head_is_last) begin
                    change_next = 1'b1;
                    state_next  = ST_IDLE;
                end
            end
            default: begin
                if (drop_pop && head_is_last) begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= {w_flit_type_i, w_flit_i};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg  <= '0;
            rd_ptr_reg  <= '0;
            count_reg   <= '0;
            w_ready_reg <= 1'b0;
            state_reg   <= ST_IDLE;
            route_reg   <= ROUTE_NONE;
            err_reg     <= 1'b0;
            change_reg  <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            end
            count_reg   <= count_next;
            // Looking at the next count keeps ready exact despite being registered.
            w_ready_reg <= (count_next != FULL_CNT);
            state_reg   <= state_next;
            route_reg   <= route_next;
            err_reg     <= err_next;
            change_reg  <= change_next;
        end
    end

    assign w_ready_o        = w_ready_reg;
    assign w_nexthop_addr_o = ((state_reg == ST_WAIT_GRANT) || (state_reg == ST_FORWARD))
                              ? route_reg : ROUTE_NONE;
    assign xbar_flit_o      = head_entry;
    assign xbar_valid_o     = valid_int;
    assign change_order_o   = change_reg;
    assign err_o            = err_reg;

endmodule

// File: tb/tb_w_inport_requester.sv
// Scoreboard bench for w_inport_requester: a packet-level model queues the expected
// crossbar deliveries and pulse counts; a negedge monitor compares what appears.
module tb_w_inport_requester;
    localparam int         FLIT_W = 32;
    localparam logic [3:0] MY_X   = 4'd1;
    localparam logic [3:0] MY_Y   = 4'd1;

    logic              clk = 1'b0;
    logic              reset;
    logic [FLIT_W-1:0] w_flit_i;
    logic [1:0]        w_flit_type_i;
    logic              w_valid_i;
    logic              w_ready_o;
    logic [2:0]        w_nexthop_addr_o;
    logic              n_grant_w_i, s_grant_w_i, e_grant_w_i, l_grant_w_i;
    logic [FLIT_W+1:0] xbar_flit_o;
    logic              xbar_valid_o;
    logic              xbar_ready_i;
    logic              change_order_o;
    logic              err_o;

    w_inport_requester #(.FLIT_W(FLIT_W), .FIFO_DEPTH(4), .MY_X(MY_X), .MY_Y(MY_Y)) dut (
        .clk(clk), .reset(reset),
        .w_flit_i(w_flit_i), .w_flit_type_i(w_flit_type_i), .w_valid_i(w_valid_i),
        .w_ready_o(w_ready_o), .w_nexthop_addr_o(w_nexthop_addr_o),
        .n_grant_w_i(n_grant_w_i), .s_grant_w_i(s_grant_w_i),
        .e_grant_w_i(e_grant_w_i), .l_grant_w_i(l_grant_w_i),
        .xbar_flit_o(xbar_flit_o), .xbar_valid_o(xbar_valid_o), .xbar_ready_i(xbar_ready_i),
        .change_order_o(change_order_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    typedef struct { logic [1:0] ftype; logic [31:0] data; } tx_t;
    typedef struct { logic [1:0] ftype; logic [31:0] data; logic [2:0] route; } exp_t;

    tx_t  tx_q[$];
    exp_t exp_q[$];
    int   vectors = 0;
    int   miscompares = 0;
    int   exp_err = 0, exp_chg = 0;
    int   err_seen = 0, chg_seen = 0;
    int   mode = 0;  // 0 manual, 1 toggle xbar_ready, 2 random grants/ready

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Routing rule written straight from the XY description; 111 marks a U-turn.
    function automatic logic [2:0] model_route(input int dx, input int dy);
        if (dx > int'(MY_X)) return 3'b011;
        if (dx < int'(MY_X)) return 3'b111;
        if (dy > int'(MY_Y)) return 3'b000;
        if (dy < int'(MY_Y)) return 3'b001;
        return 3'b100;
    endfunction

    function automatic logic grant_of(input logic [2:0] port);
        case (port)
            3'b000:  return n_grant_w_i;
            3'b001:  return s_grant_w_i;
            3'b011:  return e_grant_w_i;
            3'b100:  return l_grant_w_i;
            default: return 1'b0;
        endcase
    endfunction

    task automatic queue_packet(input int dx, input int dy, input int len, input logic [23:0] upper);
        logic [2:0] r;
        tx_t t;
        exp_t e;
        r = model_route(dx, dy);
        for (int i = 0; i < len; i++) begin
            if (len == 1)           t.ftype = 2'b11;
            else if (i == 0)        t.ftype = 2'b00;
            else if (i == len - 1)  t.ftype = 2'b10;
            else                    t.ftype = 2'b01;
            t.data = (i == 0) ? {upper, 4'(dx), 4'(dy)} : $urandom;
            tx_q.push_back(t);
            if (r != 3'b111) begin
                e.ftype = t.ftype; e.data = t.data; e.route = r;
                exp_q.push_back(e);
            end
        end
        if (r == 3'b111) exp_err++;
        else             exp_chg++;
    endtask

    task automatic queue_orphan(input logic [1:0] ftype);
        tx_t t;
        t.ftype = ftype;
        t.data  = $urandom;
        tx_q.push_back(t);
        exp_err++;
    endtask

    task automatic drive_tx(input int max_cycles, output int accepted);
        logic acc;
        accepted = 0;
        for (int c = 0; c < max_cycles && tx_q.size() > 0; c++) begin
            w_valid_i     = 1'b1;
            w_flit_type_i = tx_q[0].ftype;
            w_flit_i      = tx_q[0].data;
            acc           = w_ready_o;
            step();
            if (acc) begin
                void'(tx_q.pop_front());
                accepted++;
            end
        end
        w_valid_i = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        for (int c = 0; c < max_cycles && exp_q.size() > 0; c++) step();
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
        repeat (3) step();
        check("err_pulses", 64'(err_seen), 64'(exp_err));
        check("change_pulses", 64'(chg_seen), 64'(exp_chg));
    endtask

    task automatic set_grants(input logic n, input logic s, input logic e, input logic l);
        n_grant_w_i = n; s_grant_w_i = s; e_grant_w_i = e; l_grant_w_i = l;
    endtask

    // Environment: drives the arbiter side in the automatic modes.
    always @(posedge clk) begin
        #1;
        if (mode == 1) begin
            xbar_ready_i = ~xbar_ready_i;
        end else if (mode == 2) begin
            n_grant_w_i  = ($urandom_range(0, 9) < 7);
            s_grant_w_i  = ($urandom_range(0, 9) < 7);
            e_grant_w_i  = ($urandom_range(0, 9) < 7);
            l_grant_w_i  = ($urandom_range(0, 9) < 7);
            xbar_ready_i = ($urandom_range(0, 9) < 7);
        end
    end

    // Monitor: one line per delivered flit, compared against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (err_o)          err_seen++;
            if (change_order_o) chg_seen++;
            if (xbar_valid_o) check("valid_needs_grant", 64'(grant_of(w_nexthop_addr_o)), 64'd1);
            if (xbar_valid_o && xbar_ready_i) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL xfer_unexpected: got flit 0x%0h, required no transfer", xbar_flit_o);
                end else begin
                    e = exp_q.pop_front();
                    $display("xfer type=%0d flit=0x%08h port=%0d", xbar_flit_o[33:32],
                             xbar_flit_o[31:0], w_nexthop_addr_o);
                    check("xfer_flit", 64'(xbar_flit_o), 64'({e.ftype, e.data}));
                    check("xfer_route", 64'(w_nexthop_addr_o), 64'(e.route));
                end
            end
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: run exceeded time limit, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        tx_t t;
        reset = 1'b1;
        w_flit_i = '0; w_flit_type_i = '0; w_valid_i = 1'b0;
        set_grants(0, 0, 0, 0);
        xbar_ready_i = 1'b0;
        repeat (3) step();
        check("rst_ready", 64'(w_ready_o), 64'd0);
        check("rst_nexthop", 64'(w_nexthop_addr_o), 64'h7);
        check("rst_valid", 64'(xbar_valid_o), 64'd0);
        check("rst_change", 64'(change_order_o), 64'd0);
        check("rst_err", 64'(err_o), 64'd0);
        reset = 1'b0;
        step();
        check("ready_after_rst", 64'(w_ready_o), 64'd1);

        // Minimum-latency single flit to the east.
        set_grants(0, 0, 1, 0);
        xbar_ready_i = 1'b1;
        queue_packet(2, 1, 1, 24'h0);
        drive_tx(5, acc);
        check("lat_t1_nexthop", 64'(w_nexthop_addr_o), 64'h7);
        step();
        check("lat_t2_nexthop", 64'(w_nexthop_addr_o), 64'h3);
        check("lat_t2_valid", 64'(xbar_valid_o), 64'd0);
        step();
        check("lat_t3_valid", 64'(xbar_valid_o), 64'd1);
        check("lat_t3_flit", 64'(xbar_flit_o), 64'h3_0000_0021);
        step();
        check("lat_t4_change", 64'(change_order_o), 64'd1);
        check("lat_t4_valid", 64'(xbar_valid_o), 64'd0);
        step();
        check("lat_t5_change", 64'(change_order_o), 64'd0);
        drain(20);

        // Local packet, grant late, crossbar ready toggling.
        mode = 1;
        set_grants(0, 0, 0, 0);
        queue_packet(1, 1, 4, 24'hABCDEF);
        drive_tx(20, acc);
        check("tx_local", 64'(tx_q.size()), 64'd0);
        step();
        l_grant_w_i = 1'b1;
        drain(60);
        mode = 0;

        // U-turn packet is dropped, then a north packet routes normally.
        set_grants(1, 1, 1, 1);
        xbar_ready_i = 1'b1;
        queue_packet(0, 3, 3, 24'h123456);
        drive_tx(20, acc);
        for (int i = 0; i < 4; i++) begin
            check("drop_nexthop", 64'(w_nexthop_addr_o), 64'h7);
            step();
        end
        queue_packet(1, 2, 2, 24'h654321);
        drive_tx(20, acc);
        drain(40);

        // Back-pressure: six flits, crossbar stalled.
        set_grants(0, 0, 1, 0);
        xbar_ready_i = 1'b0;
        queue_packet(3, 1, 6, 24'h00BEEF);
        drive_tx(6, acc);
        check("full_accepted", 64'(acc), 64'd4);
        check("full_ready", 64'(w_ready_o), 64'd0);
        xbar_ready_i = 1'b1;
        drive_tx(50, acc);
        check("full_rest", 64'(acc), 64'd2);
        drain(60);

        // Orphan body flit in IDLE.
        queue_orphan(2'b01);
        drive_tx(10, acc);
        repeat (3) step();
        check("orphan_nexthop", 64'(w_nexthop_addr_o), 64'h7);
        drain(20);

        // Reset in FORWARD with three flits buffered; the model expects nothing out.
        xbar_ready_i = 1'b0;
        t.ftype = 2'b00; t.data = 32'h0000_0021; tx_q.push_back(t);
        t.ftype = 2'b01; t.data = 32'hAAAA_0001; tx_q.push_back(t);
        t.ftype = 2'b01; t.data = 32'hAAAA_0002; tx_q.push_back(t);
        drive_tx(10, acc);
        check("rstfwd_accepted", 64'(acc), 64'd3);
        for (int i = 0; i < 10 && !xbar_valid_o; i++) step();
        check("rstfwd_forward", 64'(xbar_valid_o), 64'd1);
        reset = 1'b1;
        step();
        check("rstfwd_valid", 64'(xbar_valid_o), 64'd0);
        check("rstfwd_nexthop", 64'(w_nexthop_addr_o), 64'h7);
        check("rstfwd_ready", 64'(w_ready_o), 64'd0);
        check("rstfwd_change", 64'(change_order_o), 64'd0);
        check("rstfwd_err", 64'(err_o), 64'd0);
        step();
        check("rstfwd_ready2", 64'(w_ready_o), 64'd0);
        reset = 1'b0;
        step();
        check("rstfwd_release_ready", 64'(w_ready_o), 64'd1);
        set_grants(1, 1, 1, 1);
        xbar_ready_i = 1'b1;
        repeat (6) step();
        check("rstfwd_no_valid", 64'(xbar_valid_o), 64'd0);
        drain(10);

        // Randomized traffic.
        mode = 2;
        for (int p = 0; p < 30; p++) begin
            if ($urandom_range(0, 9) == 0) begin
                queue_orphan(2'($urandom_range(1, 2)));
            end else begin
                queue_packet($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4),
                             24'($urandom));
            end
            drive_tx(300, acc);
            check("rand_tx", 64'(tx_q.size()), 64'd0);
            repeat ($urandom_range(0, 2)) step();
        end
        drain(500);
        mode = 0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/w_inport_requester.md
W_INPORT_REQUESTER -- requirements
Module: w_inport_requester

Interface
REQ-001 The block SHALL have parameter FLIT_W, default 32, flit payload width in bits.
REQ-002 The block SHALL have parameter FIFO_DEPTH, default 4, input buffer depth in flits, a power of two that is at least 2.
REQ-003 The block SHALL have parameters MY_X and MY_Y, default 0 each, the 4-bit router coordinates.
REQ-004 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port w_flit_i, input, FLIT_W bits: flit from the west link; a head flit carries dest X in [7:4] and dest Y in [3:0].
REQ-007 Port w_flit_type_i, input, 2 bits: 00 HEAD, 01 BODY, 10 TAIL, 11 SINGLE.
REQ-008 Port w_valid_i, input, 1 bit: the link flit is valid.
REQ-009 Port w_ready_o, output, 1 bit: the buffer can accept a flit.
REQ-010 Port w_nexthop_addr_o, output, 3 bits: request to the output arbiters, encoded 000 N, 001 S, 010 W, 011 E, 100 L, 111 none.
REQ-011 Ports n_grant_w_i, s_grant_w_i, e_grant_w_i and l_grant_w_i, input, 1 bit each: grant to west from each output arbiter.
REQ-012 Port xbar_flit_o, output, FLIT_W+2 bits: {type, flit} driven to the crossbar.
REQ-013 Port xbar_valid_o, output, 1 bit: the crossbar flit is valid.
REQ-014 Port xbar_ready_i, input, 1 bit: the granted output port accepts the flit.
REQ-015 Port change_order_o, output, 1 bit: one-cycle pulse that rotates the round-robin registers.
REQ-016 Port err_o, output, 1 bit: one-cycle pulse on an illegal route or an orphan flit.

Function
REQ-017 The FIFO SHALL push {type, flit} when w_valid_i and w_ready_o are both 1.
REQ-018 w_ready_o SHALL be registered and SHALL equal (count != FIFO_DEPTH); a push while full SHALL never occur, and no flit SHALL be lost or duplicated.
REQ-019 The FIFO SHALL pop on a crossbar transfer (xbar_valid_o and xbar_ready_i both 1) or on a DROP-state pop.
REQ-020 A simultaneous push and pop SHALL leave count unchanged, and read/write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-021 The FSM SHALL have the states IDLE, WAIT_GRANT, FORWARD and DROP.
REQ-022 In IDLE, with a non-empty FIFO and a HEAD or SINGLE head flit, the block SHALL register the route and go to WAIT_GRANT.
REQ-023 In IDLE, with a BODY or TAIL head flit (orphan), the block SHALL pop it, pulse err_o next cycle and stay in IDLE.
REQ-024 The route SHALL be E if destX > MY_X, else N if destY > MY_Y, else S if destY < MY_Y, else L when destX == MY_X.
REQ-025 If destX < MY_X (a U-turn), the block SHALL go to DROP, pulse err_o next cycle and never request.
REQ-026 w_nexthop_addr_o SHALL be 111 in IDLE and DROP, and SHALL hold the registered route in WAIT_GRANT and FORWARD.
REQ-027 In WAIT_GRANT, the grant of the routed port SHALL move the FSM to FORWARD next cycle, and grants of other ports SHALL be ignored.
REQ-028 In FORWARD, xbar_valid_o SHALL equal (FIFO non-empty AND routed grant), and xbar_flit_o SHALL be the FIFO head.
REQ-029 If the grant drops mid-packet, xbar_valid_o SHALL fall to 0 and the FSM SHALL stay in FORWARD.
REQ-030 A transfer of a TAIL or SINGLE flit SHALL return the FSM to IDLE and pulse change_order_o exactly one cycle later.
REQ-031 In DROP, the block SHALL pop one flit per cycle while non-empty, and popping TAIL or SINGLE SHALL return it to IDLE with no change_order_o pulse.
REQ-032 Minimum latency SHALL be: head pushed at cycle t, request at t+2, and with the grant present at t+2, xbar_valid_o at t+3.
REQ-033 One packet SHALL be in flight at a time; the next head is routed only in IDLE.

Reset
REQ-034 While reset is 1, the FSM SHALL be IDLE and count, pointers, w_ready_o, xbar_valid_o, change_order_o and err_o SHALL be 0.
REQ-035 While reset is 1, w_nexthop_addr_o SHALL be 111.
REQ-036 After reset deasserts, w_ready_o SHALL be 1 from the first cycle.
REQ-037 A reset mid-packet SHALL discard the FIFO contents with no change_order_o or err_o pulse.

Verification
REQ-038 MY_X=1, MY_Y=1, SINGLE flit 0x00000021 (dest 2,1), e_grant_w_i held 1 -> w_nexthop_addr_o=011 at t+2, flit on xbar at t+3, change_order_o=1 at t+4.
REQ-039 HEAD to (1,1), 2 BODY, TAIL; l_grant_w_i low for 5 cycles then high, xbar_ready_i toggling -> 4 flits delivered in order, nexthop=100, one change_order_o pulse.
REQ-040 HEAD to (0,3) with MY_X=1 -> err_o pulses once, all 3 packet flits dropped, nexthop stays 111, no change_order_o, next packet routes normally.
REQ-041 Push 6 back-to-back flits with xbar_ready_i=0 -> w_ready_o=0 after 4 accepted, no overflow, all 6 later delivered in order.
REQ-042 Orphan BODY flit in IDLE -> popped, err_o pulse, FSM stays IDLE.
REQ-043 Reset asserted in FORWARD with 3 flits buffered -> next cycle count=0, xbar_valid_o=0, nexthop=111, w_ready_o=0 until reset release.
